// File: rtl/div_unit_pkg.sv
// Shared wire records and unit-local state for the execute-stage divider.
// Operand width, request/response records and the divider's register record live here.
package div_unit_pkg;

    localparam int XLEN = 32;
    localparam int CNTW = 5;

    typedef struct packed {
        logic div;
        logic divu;
        logic rem;
        logic remu;
    } div_operation_type;

    typedef struct packed {
        logic [XLEN-1:0]   rdata1;
        logic [XLEN-1:0]   rdata2;
        logic              enable;
        div_operation_type div_op;
    } div_in_type;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            ready;
    } div_out_type;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;

    // rem is one bit wider than the operands so the restoring compare never wraps
    typedef struct packed {
        logic [1:0]        state;
        div_operation_type op;
        logic              neg_q;
        logic              neg_r;
        logic              dbz;
        logic              ovf;
        logic [CNTW-1:0]   cnt;
        logic [XLEN:0]     rem;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   dvs;
        logic [XLEN-1:0]   result;
        logic              ready;
    } div_reg_type;

    localparam div_reg_type init_div_reg = '0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are latched at start; one quotient bit per cycle, then a sign-fix cycle.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  div_in_type  div_in,
    output div_out_type div_out
);

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    div_reg_type r, rin;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    always_comb begin
        div_reg_type            v;
        logic                   signed_op;
        logic signed [XLEN-1:0] a_s;
        logic signed [XLEN-1:0] b_s;
        logic                   neg_a;
        logic                   neg_b;
        logic                   dbz;
        logic                   ovf;
        logic [XLEN:0]          rem_sh;
        logic [XLEN-1:0]        quo_sh;
        logic [XLEN-1:0]        q_fix;
        logic [XLEN-1:0]        r_fix;

        v         = r;
        signed_op = div_in.div_op.div | div_in.div_op.rem;
        a_s       = signed'(div_in.rdata1);
        b_s       = signed'(div_in.rdata2);
        neg_a     = signed_op && (a_s < 0);
        neg_b     = signed_op && (b_s < 0);
        dbz       = (div_in.rdata2 == '0);
        ovf       = signed_op && (div_in.rdata1 == SMIN) && (div_in.rdata2 == '1);
        rem_sh    = '0;
        quo_sh    = '0;
        q_fix     = '0;
        r_fix     = '0;

        case (r.state)
            DIV_IDLE: begin
                v.ready = 1'b0;
                // A still-high enable during the ready cycle belongs to the finished op
                if (div_in.enable && !r.ready) begin
                    v.op    = div_in.div_op;
                    v.neg_q = neg_a ^ neg_b;
                    v.neg_r = neg_a;
                    v.dbz   = dbz;
                    v.ovf   = ovf;
                    v.rem   = '0;
                    // Special cases keep the raw dividend: it is the remainder (div by 0) or the quotient (overflow)
                    v.quo   = (dbz || ovf) ? div_in.rdata1 : cond_neg(div_in.rdata1, neg_a);
                    v.dvs   = cond_neg(div_in.rdata2, neg_b);
                    v.cnt   = CNTW'(XLEN - 1);
                    v.state = (dbz || ovf) ? DIV_FIX : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (!div_in.enable) begin
                    v.state = DIV_IDLE;
                    v.ready = 1'b0;
                end else begin
                    rem_sh = (r.rem << 1) | {{XLEN{1'b0}}, r.quo[XLEN-1]};
                    quo_sh = {r.quo[XLEN-2:0], 1'b0};
                    if (rem_sh >= {1'b0, r.dvs}) begin
                        rem_sh    = rem_sh - {1'b0, r.dvs};
                        quo_sh[0] = 1'b1;
                    end
                    v.rem = rem_sh;
                    v.quo = quo_sh;
                    v.cnt = r.cnt - CNTW'(1);
                    if (r.cnt == '0) v.state = DIV_FIX;
                end
            end
            DIV_FIX: begin
                v.state = DIV_IDLE;
                if (!div_in.enable) begin
                    v.ready = 1'b0;
                end else begin
                    q_fix = r.dbz ? '1 : (r.ovf ? r.quo : cond_neg(r.quo, r.neg_q));
                    r_fix = r.dbz ? r.quo : (r.ovf ? '0 : cond_neg(r.rem[XLEN-1:0], r.neg_r));
                    v.result = (r.op.div | r.op.divu) ? q_fix :
                               ((r.op.rem | r.op.remu) ? r_fix : '0);
                    v.ready  = 1'b1;
                end
            end
            default: begin
                v.state = DIV_IDLE;
                v.ready = 1'b0;
            end
        endcase

        rin = v;
    end

    always_ff @(posedge clk) begin
        if (!rst) r <= init_div_reg;
        else      r <= rin;
    end

    assign div_out.result = r.result;
    assign div_out.ready  = r.ready;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, abort, reset and
// randomized operations against an arithmetic reference model.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    div_in_type  div_in;
    div_out_type div_out;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] SMIN = 32'h8000_0000;

    div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .div_in  (div_in),
        .div_out (div_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic div_operation_type mk_op(input int k);
        div_operation_type op;
        op = '0;
        case (k)
            0:       op.div  = 1'b1;
            1:       op.divu = 1'b1;
            2:       op.rem  = 1'b1;
            default: op.remu = 1'b1;
        endcase
        return op;
    endfunction

    // Reference: RISC-V M-extension semantics from plain SV arithmetic
    function automatic logic [31:0] ref_res(input div_operation_type op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (op.divu) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        if (op.remu) return (b == 0) ? a : a % b;
        if (b == 0) return op.div ? 32'hFFFF_FFFF : a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return op.div ? SMIN : 32'h0;
        if (op.div) return 32'(sa / sb);
        return 32'(sa % sb);
    endfunction

    function automatic int ref_lat(input div_operation_type op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 0) return 2;
        if ((op.div || op.rem) && a == SMIN && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input div_operation_type op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input bit keep_en);
        int n;
        n = 0;
        div_in.div_op = op;
        div_in.rdata1 = a;
        div_in.rdata2 = b;
        div_in.enable = 1'b1;
        do begin
            tick();
            n++;
            if (n == 1) begin
                div_in.rdata1 = $urandom;
                div_in.rdata2 = $urandom;
                div_in.div_op = mk_op(int'($urandom_range(0, 3)));
            end
        end while (!div_out.ready && n < 100);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_res"}, div_out.result, exp_res);
        if (!keep_en) div_in.enable = 1'b0;
        tick();
        chk({tag, "_pulse"}, {31'b0, div_out.ready}, 32'h0);
    endtask

    initial begin
        logic              seen;
        logic [31:0]       a, b;
        div_operation_type op;

        rst    = 1'b0;
        div_in = '0;
        repeat (3) tick();
        chk("rst_ready", {31'b0, div_out.ready}, 32'h0);
        chk("rst_result", div_out.result, 32'h0);
        rst = 1'b1;
        tick();

        run_op("divu_100_7", mk_op(1), 32'd100, 32'd7, 32'd14, 34, 1'b0);
        run_op("remu_100_7", mk_op(3), 32'd100, 32'd7, 32'd2, 34, 1'b0);
        run_op("div_m7_2", mk_op(0), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
        run_op("rem_m7_2", mk_op(2), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("rem_7_m2", mk_op(2), 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b0);
        run_op("div_ovf", mk_op(0), SMIN, 32'hFFFF_FFFF, SMIN, 2, 1'b0);
        run_op("rem_ovf", mk_op(2), SMIN, 32'hFFFF_FFFF, 32'h0, 2, 1'b0);
        run_op("divu_dbz", mk_op(1), 32'h1234, 32'h0, 32'hFFFF_FFFF, 2, 1'b0);
        run_op("rem_dbz", mk_op(2), 32'h1234, 32'h0, 32'h1234, 2, 1'b0);

        // Abort: enable drops in cycle 10, re-enabled in cycle 12
        div_in.div_op = mk_op(1);
        div_in.rdata1 = 32'd1000;
        div_in.rdata2 = 32'd3;
        div_in.enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= div_out.ready;
        end
        div_in.enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            seen |= div_out.ready;
        end
        chk("abort_no_ready", {31'b0, seen}, 32'h0);
        chk("abort_result_kept", div_out.result, 32'h1234);
        run_op("divu_9_3", mk_op(1), 32'd9, 32'd3, 32'd3, 34, 1'b0);

        // Back-to-back with enable held throughout
        run_op("b2b_divu_50_5", mk_op(1), 32'd50, 32'd5, 32'd10, 34, 1'b1);
        run_op("b2b_remu_50_6", mk_op(3), 32'd50, 32'd6, 32'd2, 34, 1'b0);

        // Reset mid-BUSY
        div_in.div_op = mk_op(1);
        div_in.rdata1 = 32'd12345;
        div_in.rdata2 = 32'd7;
        div_in.enable = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        chk("midrst_ready", {31'b0, div_out.ready}, 32'h0);
        chk("midrst_result", div_out.result, 32'h0);
        rst = 1'b1;
        div_in.enable = 1'b0;
        tick();
        run_op("post_rst_div", mk_op(0), 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 1'b0);

        for (int t = 0; t < 40; t++) begin
            op = mk_op(int'($urandom_range(0, 3)));
            case ($urandom_range(0, 7))
                0: begin a = $urandom; b = 32'h0; end
                1: begin a = SMIN; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
                3: begin a = $urandom; b = 32'($urandom_range(0, 31)) - 32'd16; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op($sformatf("rnd%0d", t), op, a, b, ref_res(op, a, b), ref_lat(op, a, b),
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
